// File: rtl/sr_mul_pipe.sv
// sr_mul_pipe: elastic multiplier, MUL/MULH/MULHSU/MULHU if SR_MUL_HIGH_EN is defined, else MUL only.
// Latency: STAGES cycles from accept to out_valid when not stalled; one op per cycle throughput.
// Backpressure: an out_ready stall holds out_*, bubbles collapse, and in_ready drops only when every stage is full and blocked.
module sr_mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    input  logic [TAG_W-1:0] qry_tag,
    output logic             qry_hit
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] dat;
    } stage_t;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    stage_t            stg [STAGES];
    logic [WIDTH-1:0]  prod_word;
    logic              acc;
    logic              hole;

`ifdef SR_MUL_HIGH_EN
    logic [WIDTH:0]     a_x;
    logic [WIDTH:0]     b_x;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;

    // Only MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned.
    always_comb begin
        a_x       = {in_a[WIDTH-1] & (in_op != 2'b11), in_a};
        b_x       = {in_b[WIDTH-1] & ~in_op[1], in_b};
        a_ext     = {{(WIDTH-1){a_x[WIDTH]}}, a_x};
        b_ext     = {{(WIDTH-1){b_x[WIDTH]}}, b_x};
        prod      = a_ext * b_ext;
        prod_word = (in_op == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end
`else
    logic [1:0] unused_op;
    assign unused_op = in_op;
    assign prod_word = in_a * in_b;
`endif

    // A stage advances iff some stage above it is empty or the output is being taken.
    always_comb begin
        hole = 1'b0;
        adv  = '0;
        for (int k = 0; k < STAGES; k++) begin
            hole = out_ready;
            for (int j = k + 1; j < STAGES; j++) begin
                hole = hole | ~vld[j];
            end
            adv[k] = vld[k] & hole;
        end
    end

    assign in_ready = ~vld[0] | adv[0];
    assign acc      = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg[k] <= '0;
            end
        end else if (flush) begin
            vld <= '0;
        end else begin
            if (acc) begin
                stg[0] <= '{tag: in_tag, dat: prod_word};
            end
            vld[0] <= acc | (vld[0] & ~adv[0]);
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k-1]) begin
                    stg[k] <= stg[k-1];
                end
                vld[k] <= adv[k-1] | (vld[k] & ~adv[k]);
            end
        end
    end

    always_comb begin
        qry_hit = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (vld[k] && (stg[k].tag == qry_tag)) begin
                qry_hit = 1'b1;
            end
        end
        if (qry_tag == '0) begin
            qry_hit = 1'b0;
        end
    end

    assign out_valid  = vld[STAGES-1];
    assign out_result = stg[STAGES-1].dat;
    assign out_tag    = stg[STAGES-1].tag;

endmodule

// File: tb/tb_sr_mul_pipe.sv
// Bench for sr_mul_pipe: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based in-flight model.
module tb_sr_mul_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic [TAG_W-1:0] qry_tag;
    logic             qry_hit;

    sr_mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .qry_tag(qry_tag), .qry_hit(qry_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference product from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
`ifdef SR_MUL_HIGH_EN
        begin
            longint sa;
            longint sb;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                2'b01:   p = sa * sb;
                2'b10:   p = sa * longint'(ub);
                default: p = ua * ub;
            endcase
        end
        return (op == 2'b00) ? p[31:0] : p[63:32];
`else
        p = ua * ub;
        return (op == 2'b00) ? p[31:0] : p[31:0];
`endif
    endfunction

    typedef struct {
        int               c;
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mq [$];
    logic [TAG_W-1:0] delivered [$];
    int               cyc = 0;
    int               last_take = -1;

    // Entry accepted in cycle c is visible from cycle c+STAGES, and no earlier than
    // one cycle after its predecessor was taken.
    always @(negedge clk) begin
        logic exp_vld;
        logic exp_rdy;
        logic exp_hit;
        if (rst) begin
            mq.delete();
            last_take = cyc;
        end else begin
            exp_vld = (mq.size() > 0) && (cyc >= mq[0].c + STAGES) && (cyc >= last_take + 1);
            chk("out_valid", out_valid, exp_vld);
            if (exp_vld) begin
                chk("out_result", out_result, mq[0].res);
                chk("out_tag", out_tag, mq[0].tag);
            end
            exp_rdy = (mq.size() < STAGES) || out_ready;
            chk("in_ready", in_ready, exp_rdy);
            exp_hit = 1'b0;
            if (qry_tag != '0) begin
                foreach (mq[i]) if (mq[i].tag == qry_tag) exp_hit = 1'b1;
            end
            chk("qry_hit", qry_hit, exp_hit);
            if (flush) begin
                mq.delete();
                last_take = cyc;
            end else begin
                if (exp_vld && out_ready) begin
                    delivered.push_back(out_tag);
                    void'(mq.pop_front());
                    last_take = cyc;
                end
                if (in_valid && exp_rdy) begin
                    mq.push_back('{c: cyc, res: ref_mul(in_op, in_a, in_b), tag: in_tag});
                end
            end
        end
        cyc++;
    end

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] lit [4];
    int          n;
    int          base;

    initial begin
`ifdef SR_MUL_HIGH_EN
        lit[0] = 32'h0000_0001; lit[1] = 32'h0000_0000; lit[2] = 32'hFFFF_FFFF; lit[3] = 32'hFFFF_FFFE;
`else
        lit[0] = 32'h0000_0001; lit[1] = 32'h0000_0001; lit[2] = 32'h0000_0001; lit[3] = 32'h0000_0001;
`endif
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0; qry_tag = 5'd3;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_tag", out_tag, 5'd0);
        chk("rst_qry_hit", qry_hit, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Nominal latency, 7*6.
        drive(1'b1, 2'b00, 32'd7, 32'd6, 5'd3, 1'b1, 1'b0);
        idle(1'b1); #1;
        chk("lat_early_valid", out_valid, 1'b0);
        idle(1'b1); #1;
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_result", out_result, 32'd42);
        chk("lat_tag", out_tag, 5'd3);
        idle(1'b1); idle(1'b1);

        // All four ops on all-ones operands, back to back.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, 2'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i + 1), 1'b1, 1'b0);
            else       idle(1'b1);
            #1;
            if (i >= 2) chk("ops_ones", out_result, lit[i-2]);
        end
        idle(1'b1); idle(1'b1);

        // Back-pressure: out_ready low for the first three cycles.
        base = delivered.size();
        n = 1;
        for (int i = 0; i < 12; i++) begin
            drive(n <= 4, 2'b00, 32'(n), 32'(n + 1), 5'(n), i >= 3, 1'b0);
            #1;
            if (i == 2) chk("bp_in_ready_low", in_ready, 1'b0);
            if (in_valid && in_ready) n++;
        end
        chk("bp_count", 64'(delivered.size() - base), 64'd4);
        if (delivered.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) chk("bp_order", delivered[base+i], 64'(i + 1));
        end

        // Hazard query.
        qry_tag = 5'd5;
        drive(1'b1, 2'b00, 32'd2, 32'd3, 5'd5, 1'b0, 1'b0); #1;
        chk("hz_issue", qry_hit, 1'b0);
        idle(1'b0); #1; chk("hz_stage0", qry_hit, 1'b1);
        idle(1'b0); #1; chk("hz_output", qry_hit, 1'b1);
        idle(1'b1); #1; chk("hz_taking", qry_hit, 1'b1);
        idle(1'b1); #1; chk("hz_after", qry_hit, 1'b0);
        qry_tag = 5'd0;
        drive(1'b1, 2'b00, 32'd1, 32'd1, 5'd0, 1'b1, 1'b0);
        idle(1'b1); #1; chk("hz_x0", qry_hit, 1'b0);
        idle(1'b1); idle(1'b1);

        // Flush with two ops in flight and a new op offered in the same cycle.
        qry_tag = 5'd7;
        base = delivered.size();
        drive(1'b1, 2'b00, 32'd4, 32'd4, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 32'd5, 32'd5, 5'd8, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 32'd6, 32'd6, 5'd7, 1'b1, 1'b1);
        idle(1'b1); #1;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_qry_hit", qry_hit, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("fl_none_later", 64'(delivered.size() - base), 64'd0);

        // Asynchronous reset mid-stream.
        qry_tag = 5'd9;
        drive(1'b1, 2'b00, 32'd3, 32'd5, 5'd9, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 32'd3, 32'd6, 5'd10, 1'b0, 1'b0);
        idle(1'b0); #1;
        chk("ar_pre_valid", out_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_out_result", out_result, 32'h0);
        chk("ar_qry_hit", qry_hit, 1'b0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        drive(1'b1, 2'b00, 32'd11, 32'd13, 5'd4, 1'b1, 1'b0);
        idle(1'b1); #1; chk("ar_lat_early", out_valid, 1'b0);
        idle(1'b1); #1;
        chk("ar_lat_valid", out_valid, 1'b1);
        chk("ar_lat_result", out_result, 32'd143);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(),
                  5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
            qry_tag = 5'($urandom_range(0, 31));
        end
        for (int i = 0; i < 2 * STAGES + 4; i++) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
